iccm_arbiter: RTL and testbench

Two-port arbiter and boot sequencer in front of the instruction-memory macro wrapper. Shares the single ICCM port between the core fetch unit (read-only) and a host/loader port (read/write with byte mask). Holds fetch off during a boot phase while the loader programs the memory, then arbitrates round-robin. Routes each one-cycle-latency read response back to the requester that issued it.

---
 rtl/iccm_arbiter_if.sv | 41 ++++
 rtl/iccm_arbiter.sv | 67 ++++++
 tb/tb_iccm_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/iccm_arbiter_if.sv
// iccm_arbiter_if: fetch, host and memory-side signals of the ICCM arbiter
//   fetch : f_req, f_addr -> f_gnt, f_rdata, f_rvalid
//   host  : h_req, h_we, h_addr, h_wdata, h_wmask -> h_gnt, h_rdata, h_rvalid, h_err
//   memory: mem_req, mem_we, mem_addr, mem_wdata, mem_wmask <- mem_rdata, mem_rvalid
//   slave modport = arbiter view, master modport = requesters/memory view
interface iccm_arbiter_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic                    f_req;
   logic [ADDR_WIDTH-1:0]   f_addr;
   logic                    f_gnt;
   logic [DATA_WIDTH-1:0]   f_rdata;
   logic                    f_rvalid;
   logic                    h_req;
   logic                    h_we;
   logic [ADDR_WIDTH-1:0]   h_addr;
   logic [DATA_WIDTH-1:0]   h_wdata;
   logic [DATA_WIDTH/8-1:0] h_wmask;
   logic                    h_gnt;
   logic [DATA_WIDTH-1:0]   h_rdata;
   logic                    h_rvalid;
   logic                    h_err;
   logic                    mem_req;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH/8-1:0] mem_wmask;
   logic [DATA_WIDTH-1:0]   mem_rdata;
   logic                    mem_rvalid;
   modport slave (
      input  f_req, f_addr, h_req, h_we, h_addr, h_wdata, h_wmask, mem_rdata, mem_rvalid,
      output f_gnt, f_rdata, f_rvalid, h_gnt, h_rdata, h_rvalid, h_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
   );
   modport master (
      output f_req, f_addr, h_req, h_we, h_addr, h_wdata, h_wmask, mem_rdata, mem_rvalid,
      input  f_gnt, f_rdata, f_rvalid, h_gnt, h_rdata, h_rvalid, h_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/iccm_arbiter.sv
// iccm_arbiter: boot sequencer + round-robin arbiter sharing one ICCM port between fetch and host
//   clock, reset (sync, active-high), boot_done (level, leaves BOOT), booting (high in BOOT)
//   bus: iccm_arbiter_if.slave carrying fetch, host and memory ports
//   ICCM_ARB_WPROT_EN: when defined, host writes in RUN are granted, dropped and answered with h_err
module iccm_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter bit BOOT_HOLD  = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic boot_done,
   output logic booting,
   iccm_arbiter_if.slave bus
);
   typedef enum logic {BOOT, RUN} state_t;
   state_t state;
   logic pri;
   logic o_valid, o_host, o_write, o_err;
   logic run, wp, h_fwd;
   always_comb begin
      run = state == RUN;
`ifdef ICCM_ARB_WPROT_EN
      wp = run && bus.h_we;
`else
      wp = 1'b0;
`endif
      // pri = 0 favours fetch, 1 favours host; fetch is never granted in BOOT
      bus.f_gnt = !reset && run && bus.f_req && (!bus.h_req || !pri);
      bus.h_gnt = !reset && bus.h_req && (!run || !bus.f_req || pri);
      // a protected write still consumes the slot but never reaches memory
      h_fwd = bus.h_gnt && !wp;
      bus.mem_req = bus.f_gnt || h_fwd;
      bus.mem_we = h_fwd && bus.h_we;
      bus.mem_addr = bus.f_gnt ? bus.f_addr : h_fwd ? bus.h_addr : '0;
      bus.mem_wdata = h_fwd ? bus.h_wdata : '0;
      bus.mem_wmask = h_fwd ? bus.h_wmask : '0;
      // responses are steered by the owner of last cycle's grant; writes answer locally
      bus.f_rvalid = !reset && o_valid && !o_host && bus.mem_rvalid;
      bus.f_rdata = bus.f_rvalid ? bus.mem_rdata : '0;
      bus.h_rvalid = !reset && o_valid && o_host && (o_write || bus.mem_rvalid);
      bus.h_rdata = (bus.h_rvalid && !o_write) ? bus.mem_rdata : '0;
      bus.h_err = bus.h_rvalid && o_err;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= BOOT_HOLD ? BOOT : RUN;
         booting <= BOOT_HOLD;
         pri     <= 1'b0;
         o_valid <= 1'b0;
         o_host  <= 1'b0;
         o_write <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         if (state == BOOT && boot_done) begin
            state   <= RUN;
            booting <= 1'b0;
         end
         if (run && (bus.f_gnt || bus.h_gnt))
            pri <= bus.f_gnt;
         o_valid <= bus.f_gnt || bus.h_gnt;
         o_host  <= bus.h_gnt;
         o_write <= bus.h_gnt && bus.h_we;
         o_err   <= bus.h_gnt && wp;
      end
   end
endmodule

// File: tb/tb_iccm_arbiter.sv
// tb_iccm_arbiter: directed checks of boot load, boot exit, round-robin, pipelining, write protect and reset
module tb_iccm_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;
`ifdef ICCM_ARB_WPROT_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic boot_done = 1'b0;
   logic booting;
   int n_chk = 0;
   int n_pass = 0;
   logic [DW-1:0] mem [0:4095];
   iccm_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   iccm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BOOT_HOLD(1'b1)) dut (
      .clock(clock),
      .reset(reset),
      .boot_done(boot_done),
      .booting(booting),
      .bus(bus.slave)
   );
   always #5 clock = ~clock;
   always @(posedge clock) begin
      bus.mem_rvalid <= bus.mem_req && !bus.mem_we;
      bus.mem_rdata <= (bus.mem_req && !bus.mem_we) ? mem[bus.mem_addr] : '0;
      if (reset) begin
         mem[12'h010] <= 32'h1111_0010;
         mem[12'h011] <= 32'h2222_0011;
         mem[12'h020] <= 32'hAAAA_0020;
      end else if (bus.mem_req && bus.mem_we) begin
         for (int i = 0; i < DW/8; i++)
            if (bus.mem_wmask[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask
   task automatic idle();
      bus.f_req = 1'b0;
      bus.f_addr = '0;
      bus.h_req = 1'b0;
      bus.h_we = 1'b0;
      bus.h_addr = '0;
      bus.h_wdata = '0;
      bus.h_wmask = '0;
      boot_done = 1'b0;
   endtask
   task automatic nxt();
      @(posedge clock);
      #1;
   endtask
   task automatic mid();
      @(negedge clock);
   endtask
   initial begin
      idle();
      bus.f_req = 1'b1;
      bus.h_req = 1'b1;
      nxt();
      nxt();
      mid();
      chk("rst_fgnt", 32'(bus.f_gnt), 0);
      chk("rst_hgnt", 32'(bus.h_gnt), 0);
      chk("rst_memreq", 32'(bus.mem_req), 0);
      chk("rst_booting", 32'(booting), 1);
      chk("rst_frvalid", 32'(bus.f_rvalid), 0);
      chk("rst_hrvalid", 32'(bus.h_rvalid), 0);
      chk("rst_herr", 32'(bus.h_err), 0);
      // boot load: host write wins, fetch held off
      nxt();
      reset = 1'b0;
      idle();
      bus.f_req = 1'b1;
      bus.f_addr = 12'h004;
      bus.h_req = 1'b1;
      bus.h_we = 1'b1;
      bus.h_addr = 12'h004;
      bus.h_wdata = 32'hDEAD_BEEF;
      bus.h_wmask = 4'hF;
      mid();
      chk("boot_hgnt", 32'(bus.h_gnt), 1);
      chk("boot_fgnt", 32'(bus.f_gnt), 0);
      chk("boot_memwe", 32'(bus.mem_we), 1);
      chk("boot_memaddr", 32'(bus.mem_addr), 32'h004);
      chk("boot_memwdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("boot_memwmask", 32'(bus.mem_wmask), 32'hF);
      chk("boot_booting", 32'(booting), 1);
      nxt();
      bus.h_req = 1'b0;
      bus.h_we = 1'b0;
      mid();
      chk("boot_hrvalid", 32'(bus.h_rvalid), 1);
      chk("boot_herr", 32'(bus.h_err), 0);
      chk("boot_hrdata", bus.h_rdata, 0);
      chk("boot_fgnt2", 32'(bus.f_gnt), 0);
      // boot exit: fetch first granted the cycle after boot_done
      nxt();
      boot_done = 1'b1;
      mid();
      chk("bd_fgnt", 32'(bus.f_gnt), 0);
      chk("bd_booting", 32'(booting), 1);
      nxt();
      boot_done = 1'b0;
      mid();
      chk("run_fgnt", 32'(bus.f_gnt), 1);
      chk("run_booting", 32'(booting), 0);
      chk("run_memaddr", 32'(bus.mem_addr), 32'h004);
      nxt();
      bus.f_req = 1'b0;
      mid();
      chk("run_frvalid", 32'(bus.f_rvalid), 1);
      chk("run_frdata", bus.f_rdata, 32'hDEAD_BEEF);
      // back-to-back mixed traffic
      nxt();
      bus.f_req = 1'b1;
      bus.f_addr = 12'h010;
      mid();
      chk("b2b_fgnt0", 32'(bus.f_gnt), 1);
      nxt();
      bus.f_req = 1'b0;
      bus.h_req = 1'b1;
      bus.h_addr = 12'h004;
      mid();
      chk("b2b_hgnt", 32'(bus.h_gnt), 1);
      chk("b2b_frvalid0", 32'(bus.f_rvalid), 1);
      chk("b2b_frdata0", bus.f_rdata, 32'h1111_0010);
      nxt();
      bus.h_req = 1'b0;
      bus.f_req = 1'b1;
      bus.f_addr = 12'h011;
      mid();
      chk("b2b_fgnt1", 32'(bus.f_gnt), 1);
      chk("b2b_hrvalid", 32'(bus.h_rvalid), 1);
      chk("b2b_hrdata", bus.h_rdata, 32'hDEAD_BEEF);
      chk("b2b_frvalid_idle", 32'(bus.f_rvalid), 0);
      chk("b2b_frdata_idle", bus.f_rdata, 0);
      nxt();
      idle();
      mid();
      chk("b2b_frvalid1", 32'(bus.f_rvalid), 1);
      chk("b2b_frdata1", bus.f_rdata, 32'h2222_0011);
      chk("b2b_hrvalid_idle", 32'(bus.h_rvalid), 0);
      // reset in the cycle after a fetch grant drops the response
      nxt();
      bus.f_req = 1'b1;
      bus.f_addr = 12'h010;
      mid();
      chk("mf_fgnt", 32'(bus.f_gnt), 1);
      nxt();
      reset = 1'b1;
      bus.f_req = 1'b0;
      mid();
      chk("mf_frvalid", 32'(bus.f_rvalid), 0);
      chk("mf_frdata", bus.f_rdata, 0);
      nxt();
      reset = 1'b0;
      bus.f_req = 1'b1;
      mid();
      chk("mf_frvalid2", 32'(bus.f_rvalid), 0);
      chk("mf_booting", 32'(booting), 1);
      chk("mf_fgnt_boot", 32'(bus.f_gnt), 0);
      nxt();
      bus.f_req = 1'b0;
      boot_done = 1'b1;
      // contention: both request every cycle, fetch first
      for (int k = 0; k < 6; k++) begin
         nxt();
         boot_done = 1'b0;
         bus.f_req = 1'b1;
         bus.f_addr = 12'h010;
         bus.h_req = 1'b1;
         bus.h_we = 1'b0;
         bus.h_addr = 12'h004;
         mid();
         chk($sformatf("ct%0d_fgnt", k), 32'(bus.f_gnt), 32'(k % 2 == 0));
         chk($sformatf("ct%0d_hgnt", k), 32'(bus.h_gnt), 32'(k % 2 == 1));
         if (k > 0) begin
            chk($sformatf("ct%0d_frvalid", k), 32'(bus.f_rvalid), 32'(k % 2 == 1));
            chk($sformatf("ct%0d_hrvalid", k), 32'(bus.h_rvalid), 32'(k % 2 == 0));
            chk($sformatf("ct%0d_frdata", k), bus.f_rdata, (k % 2 == 1) ? 32'h1111_0010 : 32'h0);
            chk($sformatf("ct%0d_hrdata", k), bus.h_rdata, (k % 2 == 0) ? 32'hDEAD_BEEF : 32'h0);
         end
      end
      nxt();
      idle();
      mid();
      chk("ct_last_hrvalid", 32'(bus.h_rvalid), 1);
      chk("ct_last_frvalid", 32'(bus.f_rvalid), 0);
      chk("ct_last_hrdata", bus.h_rdata, 32'hDEAD_BEEF);
      // host write in RUN: dropped and flagged when protection is built in
      nxt();
      bus.h_req = 1'b1;
      bus.h_we = 1'b1;
      bus.h_addr = 12'h020;
      bus.h_wdata = 32'h1234_5678;
      bus.h_wmask = 4'hF;
      mid();
      chk("wp_hgnt", 32'(bus.h_gnt), 1);
      chk("wp_memreq", 32'(bus.mem_req), WP ? 0 : 1);
      nxt();
      idle();
      bus.f_req = 1'b1;
      bus.f_addr = 12'h020;
      mid();
      chk("wp_hrvalid", 32'(bus.h_rvalid), 1);
      chk("wp_herr", 32'(bus.h_err), WP ? 1 : 0);
      chk("wp_hrdata", bus.h_rdata, 0);
      chk("wp_fgnt", 32'(bus.f_gnt), 1);
      nxt();
      idle();
      mid();
      chk("wp_frvalid", 32'(bus.f_rvalid), 1);
      chk("wp_frdata", bus.f_rdata, WP ? 32'hAAAA_0020 : 32'h1234_5678);
      nxt();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
